// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared core types: register/ROB widths, CDB record, requester indices
package rv32i_types;

   localparam int PHYS_REG_BITS  = 6;
   localparam int ARCH_REG_BITS  = 5;
   localparam int ROB_ADDR_WIDTH = 4;

   localparam int CDB_NUM_REQ  = 5;
   localparam int CDB_SRC_BITS = 3;

   localparam logic [CDB_SRC_BITS-1:0] CDB_SRC_ADD = 3'd0;
   localparam logic [CDB_SRC_BITS-1:0] CDB_SRC_MUL = 3'd1;
   localparam logic [CDB_SRC_BITS-1:0] CDB_SRC_DIV = 3'd2;
   localparam logic [CDB_SRC_BITS-1:0] CDB_SRC_BR  = 3'd3;
   localparam logic [CDB_SRC_BITS-1:0] CDB_SRC_MEM = 3'd4;

   typedef struct packed {
      logic                      valid;
      logic                      regf_we;
      logic [PHYS_REG_BITS-1:0]  pd;
      logic [ARCH_REG_BITS-1:0]  rd;
      logic [ROB_ADDR_WIDTH-1:0] rob;
      logic [31:0]               data;
      logic [CDB_SRC_BITS-1:0]   src;
   } cdb_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - completion-port requests and CDB broadcast bundle; CDB_PERF_CNT_EN adds perf outputs
interface cdb_arbiter_if;
   import rv32i_types::*;

   logic                                  flush;
   logic [CDB_NUM_REQ-1:0]                req_valid;
   logic [CDB_NUM_REQ*PHYS_REG_BITS-1:0]  req_pd;
   logic [CDB_NUM_REQ*ARCH_REG_BITS-1:0]  req_rd;
   logic [CDB_NUM_REQ*ROB_ADDR_WIDTH-1:0] req_rob;
   logic [CDB_NUM_REQ*32-1:0]             req_data;
   logic [CDB_NUM_REQ-1:0]                req_ready;

   logic                      cdb_valid;
   logic                      cdb_regf_we;
   logic [PHYS_REG_BITS-1:0]  cdb_pd;
   logic [ARCH_REG_BITS-1:0]  cdb_rd;
   logic [ROB_ADDR_WIDTH-1:0] cdb_rob;
   logic [31:0]               cdb_data;
   logic [CDB_SRC_BITS-1:0]   cdb_src;

`ifdef CDB_PERF_CNT_EN
   logic [31:0] perf_bcast_cnt;
   logic [31:0] perf_conflict_cnt;
   logic [7:0]  perf_max_wait;

   modport master (
      output flush, req_valid, req_pd, req_rd, req_rob, req_data,
      input  req_ready, cdb_valid, cdb_regf_we, cdb_pd, cdb_rd, cdb_rob, cdb_data, cdb_src,
      input  perf_bcast_cnt, perf_conflict_cnt, perf_max_wait
   );

   modport slave (
      input  flush, req_valid, req_pd, req_rd, req_rob, req_data,
      output req_ready, cdb_valid, cdb_regf_we, cdb_pd, cdb_rd, cdb_rob, cdb_data, cdb_src,
      output perf_bcast_cnt, perf_conflict_cnt, perf_max_wait
   );
`else
   modport master (
      output flush, req_valid, req_pd, req_rd, req_rob, req_data,
      input  req_ready, cdb_valid, cdb_regf_we, cdb_pd, cdb_rd, cdb_rob, cdb_data, cdb_src
   );

   modport slave (
      input  flush, req_valid, req_pd, req_rd, req_rob, req_data,
      output req_ready, cdb_valid, cdb_regf_we, cdb_pd, cdb_rd, cdb_rob, cdb_data, cdb_src
   );
`endif

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - generic round-robin grant starting at a pointer, one-hot plus index
module rr_arbiter #(
   parameter int NUM_REQ  = 5,
   parameter int IDX_BITS = 3
) (
   input  logic [NUM_REQ-1:0]  req_i,
   input  logic [IDX_BITS-1:0] ptr_i,
   input  logic                en_i,
   output logic [NUM_REQ-1:0]  gnt_o,
   output logic [IDX_BITS-1:0] gnt_idx_o
);

   logic found;
   int   idx;

   // Scan ptr, ptr+1, ... modulo NUM_REQ; first requesting slot wins
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr_i) + k) % NUM_REQ;
         if (en_i && !found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            gnt_idx_o  = IDX_BITS'(idx);
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB arbiter with registered broadcast; CDB_PERF_CNT_EN adds perf counters
module cdb_arbiter
   import rv32i_types::*;
(
   input logic          clk,
   input logic          rst,
   cdb_arbiter_if.slave bus_if
);

   localparam int NUM_REQ = CDB_NUM_REQ;

   logic [NUM_REQ-1:0]      gnt;
   logic [CDB_SRC_BITS-1:0] gnt_idx;
   logic [CDB_SRC_BITS-1:0] rr_ptr_q, rr_ptr_d;
   logic                    grant_en;
   cdb_t                    cdb_q, cdb_d;

   // No grant while in reset or flushing, so requesters keep their results
   assign grant_en = !rst && !bus_if.flush;

   rr_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .IDX_BITS (CDB_SRC_BITS)
   ) u_rr (
      .req_i     (bus_if.req_valid),
      .ptr_i     (rr_ptr_q),
      .en_i      (grant_en),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx)
   );

   assign bus_if.req_ready = gnt;

   // Pointer moves one past the winner; holds when nothing is granted
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (|gnt) begin
         rr_ptr_d = (gnt_idx == CDB_SRC_BITS'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   // Capture the winner's payload; without a grant only valid/we drop, payload holds
   always_comb begin
      cdb_d         = cdb_q;
      cdb_d.valid   = 1'b0;
      cdb_d.regf_we = 1'b0;
      if (|gnt) begin
         cdb_d.valid   = 1'b1;
         cdb_d.pd      = bus_if.req_pd[gnt_idx*PHYS_REG_BITS +: PHYS_REG_BITS];
         cdb_d.rd      = bus_if.req_rd[gnt_idx*ARCH_REG_BITS +: ARCH_REG_BITS];
         cdb_d.rob     = bus_if.req_rob[gnt_idx*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH];
         cdb_d.data    = bus_if.req_data[gnt_idx*32 +: 32];
         cdb_d.src     = gnt_idx;
         cdb_d.regf_we = (cdb_d.pd != '0);
      end
   end

   // Pointer and broadcast registers
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= '0;
         cdb_q    <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         cdb_q    <= cdb_d;
      end
   end

   assign bus_if.cdb_valid   = cdb_q.valid;
   assign bus_if.cdb_regf_we = cdb_q.regf_we;
   assign bus_if.cdb_pd      = cdb_q.pd;
   assign bus_if.cdb_rd      = cdb_q.rd;
   assign bus_if.cdb_rob     = cdb_q.rob;
   assign bus_if.cdb_data    = cdb_q.data;
   assign bus_if.cdb_src     = cdb_q.src;

`ifdef CDB_PERF_CNT_EN
   logic [31:0] bcast_q, bcast_d;
   logic [31:0] conflict_q, conflict_d;
   logic [7:0]  max_wait_q, max_wait_d;
   logic [7:0]  wait_q [NUM_REQ];
   logic [7:0]  wait_d [NUM_REQ];

   // Per-requester starvation run length (saturating) and the running maximum
   always_comb begin
      bcast_d    = bcast_q + {31'd0, |gnt};
      conflict_d = conflict_q;
      if (!bus_if.flush && ($countones(bus_if.req_valid) > 1)) begin
         conflict_d = conflict_q + 32'd1;
      end
      max_wait_d = max_wait_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         wait_d[i] = 8'd0;
         if (bus_if.req_valid[i] && !gnt[i]) begin
            wait_d[i] = (wait_q[i] == 8'hFF) ? 8'hFF : wait_q[i] + 8'd1;
         end
         if (wait_d[i] > max_wait_d) begin
            max_wait_d = wait_d[i];
         end
      end
   end

   // Performance counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         bcast_q    <= '0;
         conflict_q <= '0;
         max_wait_q <= '0;
         for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= '0;
      end else begin
         bcast_q    <= bcast_d;
         conflict_q <= conflict_d;
         max_wait_q <= max_wait_d;
         for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= wait_d[i];
      end
   end

   assign bus_if.perf_bcast_cnt    = bcast_q;
   assign bus_if.perf_conflict_cnt = conflict_q;
   assign bus_if.perf_max_wait     = max_wait_q;
`endif

endmodule
